// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter.
// Scheduler states, id width helper, timeout margin.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int TO_MARGIN = 4;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_arb_if.sv
// Requester and response channels of the divider arbiter.
// master = client side, slave = arbiter side.
interface div_arb_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) ();
  import div_arb_pkg::*;

  localparam int IW = id_width(N);

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_x;
  logic [N*WIDTH-1:0] req_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [WIDTH-1:0]   rsp_q;
  logic [WIDTH-1:0]   rsp_r;
  logic               rsp_dbz;
  logic               rsp_err;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_q, rsp_r, rsp_dbz, rsp_err
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_q, rsp_r, rsp_dbz, rsp_err
  );

endinterface

// File: rtl/div_arbiter_rr_pick.sv
// Round-robin picker: first request at or above ptr, with wrap.
// Double-width copy of req masked below ptr; lowest set bit wins.
module rr_pick
  import div_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] msk;

  assign dbl = {req, req};
  assign msk = dbl & ~(((2*N)'(1) << ptr) - (2*N)'(1));

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (msk[i]) begin
        gnt     = N'(1) << (i % N);
        gnt_idx = IW'(i % N);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between N requesters.
// Accept, start, wait with timeout, then return a tagged response.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N       = 4,
  parameter int TIMEOUT = WIDTH + TO_MARGIN
) (
  input  logic             clk,
  input  logic             rst,
  div_arb_if.slave         bus,
  output logic             div_start,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic             div_busy,
  input  logic             div_valid,
  input  logic             div_dbz,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam int IW = id_width(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t st, nx;

  logic [IW-1:0]    ptr, id, gidx;
  logic [N-1:0]     gnt;
  logic [WIDTH-1:0] x_q, y_q, q_q, r_q;
  logic [WIDTH-1:0] sel_x, sel_y;
  logic             dbz_q, err_q;
  logic [CW-1:0]    cnt, cnt_inc;
  logic             done, dz, tmo;

  rr_pick #(.N(N)) u_pick (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  assign cnt_inc = cnt + 1'b1;
  assign done    = !div_busy && div_valid;
  assign dz      = !div_busy && div_dbz;
  assign tmo     = cnt_inc == CW'(TIMEOUT);

  always_comb begin
    nx            = st;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    div_start     = 1'b0;
    sel_x         = '0;
    sel_y         = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) begin
        sel_x = bus.req_x[k*WIDTH +: WIDTH];
        sel_y = bus.req_y[k*WIDTH +: WIDTH];
      end
    end
    unique case (st)
      IDLE: begin
        if (|bus.req_valid) begin
          bus.req_ready = gnt;
          nx            = ISSUE;
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        nx        = WAIT;
      end
      WAIT: begin
        if (done || dz || tmo) nx = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) nx = IDLE;
      end
      default: nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      ptr   <= '0;
      id    <= '0;
      x_q   <= '0;
      y_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      st <= nx;
      unique case (st)
        IDLE: begin
          if (|bus.req_valid) begin
            id  <= gidx;
            x_q <= sel_x;
            y_q <= sel_y;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt_inc;
          // a valid result outranks dbz, which outranks timeout
          if (done || dz || tmo) begin
            q_q   <= done ? div_q : '0;
            r_q   <= done ? div_r : '0;
            dbz_q <= !done && dz;
            err_q <= !done && !dz;
          end
        end
        RESP: begin
          if (bus.rsp_ready)
            ptr <= (id == IW'(N-1)) ? '0 : id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign div_x       = x_q;
  assign div_y       = y_q;
  assign bus.rsp_id  = id;
  assign bus.rsp_q   = q_q;
  assign bus.rsp_r   = r_q;
  assign bus.rsp_dbz = dbz_q;
  assign bus.rsp_err = err_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready));

  a_start: assert property (@(posedge clk) disable iff (rst)
    div_start |-> st == ISSUE);

  a_stable: assert property (@(posedge clk) disable iff (rst)
    bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid &&
    $stable({bus.rsp_id, bus.rsp_q, bus.rsp_r,
             bus.rsp_dbz, bus.rsp_err}));

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider.
// Grant order and results predicted from round-robin rules.
module tb_div_arbiter;
  import div_arb_pkg::*;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int TO = W + 4;

  typedef struct {
    int id; int q; int r; int dbz; int err; int lat; int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_arb_if #(.WIDTH(W), .N(N)) bus ();

  logic         div_start, div_busy, div_valid, div_dbz;
  logic [W-1:0] div_x, div_y, div_q, div_r;

  div_arbiter #(.WIDTH(W), .N(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .div_start (div_start),
    .div_x     (div_x),
    .div_y     (div_y),
    .div_busy  (div_busy),
    .div_valid (div_valid),
    .div_dbz   (div_dbz),
    .div_q     (div_q),
    .div_r     (div_r)
  );

  // divider: W busy cycles then a valid pulse; y=0 flags dbz next cycle
  int       dcnt = 0;
  bit       stuck = 1'b0;
  logic     mv = 1'b0, md = 1'b0;
  logic [W-1:0] mq = '0, mr = '0;
  always @(posedge clk) begin
    mv <= 1'b0;
    md <= 1'b0;
    if (div_start) begin
      if (div_y == 0) begin
        md   <= 1'b1;
        dcnt <= 0;
      end else begin
        dcnt <= W;
        mq   <= div_x / div_y;
        mr   <= div_x % div_y;
      end
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) mv <= 1'b1;
    end
  end
  assign div_busy  = stuck || (dcnt != 0);
  assign div_valid = mv;
  assign div_dbz   = md;
  assign div_q     = mq;
  assign div_r     = mr;

  int   total = 0, bad = 0;
  int   cyc = 0;
  int   mptr = 0;
  int   n_acc = 0, n_rsp = 0;
  exp_t sb[$];
  int   grants[$];
  bit   in_rsp = 1'b0;
  logic [11:0] snap, cur;
  int   ag, ax, ay, kk, n0;
  exp_t ae;
  bit   rdy_rand = 1'b0, rdy_fix = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end
  end

  // accept monitor: predicts the grant and pushes the expected response
  initial forever begin
    @(negedge clk); #2;
    if (!rst && bus.req_ready != '0) begin
      ag = -1;
      for (int j = 0; j < N; j++) begin
        kk = (mptr + j) % N;
        if (ag < 0 && bus.req_valid[kk]) ag = kk;
      end
      chk("accept_while_busy", sb.size(), 0);
      chk("grant", int'(bus.req_ready), (ag < 0) ? 0 : (1 << ag));
      if (ag >= 0) begin
        ax = int'(bus.req_x[ag*W +: W]);
        ay = int'(bus.req_y[ag*W +: W]);
        ae.id = ag; ae.acc = cyc + 1;
        ae.q = 0; ae.r = 0; ae.dbz = 0; ae.err = 0;
        if (stuck) begin
          ae.err = 1; ae.lat = TO + 1;
        end else if (ay == 0) begin
          ae.dbz = 1; ae.lat = 2;
        end else begin
          ae.q = ax / ay; ae.r = ax % ay; ae.lat = W + 2;
        end
        sb.push_back(ae);
        grants.push_back(ag);
        n_acc++;
      end
    end
  end

  // response monitor
  initial forever begin
    @(negedge clk); #2;
    if (rst) begin
      in_rsp = 1'b0;
    end else if (bus.rsp_valid) begin
      cur = {bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.rsp_dbz, bus.rsp_err};
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d expected none",
                 bus.rsp_id);
      end else begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          snap   = cur;
          chk("latency", cyc - sb[0].acc, sb[0].lat);
        end else begin
          chk("rsp_stable", int'(cur), int'(snap));
          chk("start_in_resp", int'(div_start), 0);
          chk("grant_in_resp", int'(bus.req_ready), 0);
        end
        if (bus.rsp_ready) begin
          chk("rsp_id", int'(bus.rsp_id), sb[0].id);
          chk("rsp_q", int'(bus.rsp_q), sb[0].q);
          chk("rsp_r", int'(bus.rsp_r), sb[0].r);
          chk("rsp_dbz", int'(bus.rsp_dbz), sb[0].dbz);
          chk("rsp_err", int'(bus.rsp_err), sb[0].err);
          mptr = (sb[0].id + 1) % N;
          void'(sb.pop_front());
          in_rsp = 1'b0;
          n_rsp++;
        end
      end
    end
  end

  task automatic send(input int k, input int x, input int y);
    @(negedge clk);
    bus.req_x[k*W +: W] = W'(x);
    bus.req_y[k*W +: W] = W'(y);
    bus.req_valid[k]    = 1'b1;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (bus.req_ready[k]) begin
        @(posedge clk); #1;
        bus.req_valid[k] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL send_timeout: requester %0d got no grant expected one", k);
    bus.req_valid[k] = 1'b0;
  endtask

  task automatic burst(input logic [N-1:0] m, input int cnt);
    int base;
    @(negedge clk);
    base = n_acc;
    bus.req_valid = m;
    #3;
    for (int t = 0; t < 300 && n_acc < base + cnt; t++) begin
      @(negedge clk); #3;
    end
    if (n_acc < base + cnt) begin
      total++; bad++;
      $display("FAIL burst: got %0d grants expected %0d", n_acc - base, cnt);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic wait_rsp(input int tgt);
    for (int t = 0; t < 300 && n_rsp < tgt; t++) @(negedge clk);
    if (n_rsp < tgt) begin
      total++; bad++;
      $display("FAIL wait_rsp: got %0d responses expected %0d", n_rsp, tgt);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_div_start", int'(div_start), 0);
    chk("rst_div_x", int'(div_x), 0);
    chk("rst_div_y", int'(div_y), 0);
    chk("rst_rsp_q", int'(bus.rsp_q), 0);
    chk("rst_rsp_err", int'(bus.rsp_err), 0);
    @(negedge clk);
    rst = 1'b0;

    bus.req_x = {4'd7, 4'd11, 4'd14, 4'd15};
    bus.req_y = {4'd5, 4'd4, 4'd3, 4'd2};
    burst('1, 5);
    wait_rsp(5);
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("rr_order", grants[i], i % N);

    send(2, 13, 4);
    wait_rsp(6);
    send(1, 9, 0);
    wait_rsp(7);
    burst('1, 1);
    chk("rr_after_dbz", grants[grants.size()-1], 2);
    wait_rsp(8);

    rdy_fix = 1'b0;
    send(3, 14, 3);
    fork send(0, 7, 2); join_none
    for (int t = 0; t < 50 && !bus.rsp_valid; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    rdy_fix = 1'b1;
    wait_rsp(10);

    stuck = 1'b1;
    send(1, 5, 2);
    wait_rsp(11);
    stuck = 1'b0;
    send(2, 10, 3);
    wait_rsp(12);

    send(2, 11, 3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("midrst_div_start", int'(div_start), 0);
    chk("midrst_div_x", int'(div_x), 0);
    chk("midrst_div_y", int'(div_y), 0);
    chk("midrst_req_ready", int'(bus.req_ready), 0);
    sb.delete();
    mptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n0 = n_rsp;
    send(3, 15, 15);
    wait_rsp(n0 + 1);

    rdy_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < N; k++) begin
        bus.req_x[k*W +: W] = W'($urandom_range(0, 15));
        bus.req_y[k*W +: W] = ($urandom_range(0, 4) == 0) ?
                              '0 : W'($urandom_range(1, 15));
      end
      n0 = n_rsp;
      burst(N'($urandom_range(1, 15)), 1);
      wait_rsp(n0 + 1);
    end
    rdy_rand = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
